// File: rtl/ram_param.sv
// Parametrised single-port word RAM, byte-enable writes, 1-cycle registered response.
// Self-initialising sweep after reset or init_req; optional counters with RAM_STATS_EN.
module ram_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int INIT_MODE  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init_req,
  output logic                    init_busy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata
`ifdef RAM_STATS_EN
  ,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_acc;
  logic                    w_init_we;
  logic [DATA_WIDTH-1:0]   w_cur;
  logic [DATA_WIDTH-1:0]   w_new;
  logic [DATA_WIDTH-1:0]   w_pattern;

  assign init_busy = (r_state == S_INIT);
  assign req_ready = (r_state == S_RUN) && !init_req;
  assign w_acc     = req_valid && req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  // Sweep writes are held off while reset is low and on a restart edge
  assign w_init_we = reset && (r_state == S_INIT) && !init_req;
  assign w_pattern = (INIT_MODE == 1) ? DATA_WIDTH'(r_ptr) : '0;

  always_comb begin
    w_cur = r_mem[req_addr];
    w_new = w_cur;
    for (int k = 0; k < NB; k++) begin
      if (req_be[k]) begin
        w_new[8*k +: 8] = req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_init_we) begin
      r_mem[r_ptr] <= w_pattern;
    end else if (w_acc && req_we) begin
      r_mem[req_addr] <= w_new;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_acc;
      if (w_acc) begin
        r_rsp_rdata <= req_we ? w_new : w_cur;
      end
      if (init_req) begin
        r_state <= S_INIT;
        r_ptr   <= '0;
      end else if (r_state == S_INIT) begin
        r_ptr <= r_ptr + 1'b1;
        if (&r_ptr) begin
          r_state <= S_RUN;
        end
      end
    end
  end

`ifdef RAM_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (init_req) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_acc) begin
      if (!req_we && r_rd_count != 16'hFFFF) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (req_we && r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end
`endif

endmodule
